// File: rtl/c3po_pkg.sv
// Shared constants, state encoding and beat/word record types for the C-3PO packer.
package c3po_pkg;

    localparam int IN_BYTES  = 32;
    localparam int OUT_BYTES = 160;
    localparam int BEATS     = OUT_BYTES / IN_BYTES;
    localparam int IN_W      = IN_BYTES * 8;
    localparam int OUT_W     = OUT_BYTES * 8;
    localparam int VBC_W     = 8;
    localparam int BIDX_W    = 3;

    // Full narrow beat expressed as a byte count.
    localparam logic [VBC_W-1:0] IN_VBC = VBC_W'(IN_BYTES);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } packer_state_e;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [VBC_W-1:0] vbc;
        logic [IN_W-1:0]  data;
    } narrow_beat_t;

    typedef struct packed {
        logic             val;
        logic             sop;
        logic             eop;
        logic [VBC_W-1:0] vbc;
        logic [OUT_W-1:0] data;
    } wide_word_t;

    // A final beat must carry 1..IN_BYTES bytes; anything else is forced into range.
    function automatic logic [VBC_W-1:0] clamp_vbc(input logic [VBC_W-1:0] vbc);
        if (vbc == '0) begin
            return VBC_W'(1);
        end else if (vbc > IN_VBC) begin
            return IN_VBC;
        end else begin
            return vbc;
        end
    endfunction

endpackage

// File: rtl/c3po_packer_if.sv
// Packet stream bundle (val/sop/eop/vbc/data + rdy) used for both the narrow and wide sides.
// Handshake: a transfer happens on a rising clock edge where val and rdy are both 1.
// The master holds val and all payload fields stable while val=1 and rdy=0;
// rdy may depend combinationally on the slave's own output state but never on val.
interface c3po_packer_if #(parameter int BYTES = 32);

    logic               val;
    logic               sop;
    logic               eop;
    logic [7:0]         vbc;
    logic [BYTES*8-1:0] data;
    logic               rdy;

    modport master (output val, sop, eop, vbc, data, input rdy);
    modport slave  (input val, sop, eop, vbc, data, output rdy);

endinterface

// File: rtl/c3po_pack_acc.sv
// Accumulator for one wide word: places each narrow beat in its byte lane and counts beats.
module c3po_pack_acc
    import c3po_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,     // beat is being packed this cycle
    input  logic              restart_i,  // beat opens a new packet: ignore any partial word
    input  logic              flush_i,    // beat completes the word: clear after this edge
    input  logic [VBC_W-1:0]  vbc_i,      // bytes of the beat to keep (already range-checked)
    input  logic [IN_W-1:0]   data_i,
    output logic [OUT_W-1:0]  merged_o,   // accumulator with the current beat merged in
    output logic [BIDX_W-1:0] beat_o      // lane index the current beat lands in
);

    logic [OUT_W-1:0]  acc_q;
    logic [BIDX_W-1:0] beat_q;
    logic [IN_W-1:0]   masked;
    logic [OUT_W-1:0]  placed;

    // Zero the unused top bytes of the beat and shift it into its lane.
    always_comb begin
        masked = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (k < int'(vbc_i)) begin
                masked[8*k +: 8] = data_i[8*k +: 8];
            end
        end
        beat_o   = restart_i ? '0 : beat_q;
        placed   = OUT_W'(masked) << (int'(beat_o) * IN_W);
        merged_o = (restart_i ? '0 : acc_q) | placed;
    end

    // Keep the partial word, or clear it once it has been handed to the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            beat_q <= '0;
        end else if (load_i) begin
            if (flush_i) begin
                acc_q  <= '0;
                beat_q <= '0;
            end else begin
                acc_q  <= merged_o;
                beat_q <= beat_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/c3po_packer.sv
// Gathers 32-byte beats of a packet into 160-byte wide words with sop/eop/vbc framing.
module c3po_packer
    import c3po_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    c3po_packer_if.slave  in_if,
    c3po_packer_if.master out_if,
    output logic          err,
    output packer_state_e dbg_state
);

    narrow_beat_t      beat;
    packer_state_e     state_q;
    wide_word_t        out_q;
    logic              first_q;
    logic              err_q;

    logic              accept;
    logic              use_beat;
    logic              bad_vbc;
    logic              flush;
    logic              proto_err;
    logic              word_first;
    logic [VBC_W-1:0]  vbc_eff;
    logic [VBC_W-1:0]  word_vbc;
    logic [BIDX_W-1:0] beat_idx;
    logic [OUT_W-1:0]  merged;

    assign beat = '{sop: in_if.sop, eop: in_if.eop, vbc: in_if.vbc, data: in_if.data};

    // Stall the narrow side only while a finished word is waiting on the wide side.
    assign in_if.rdy = !(out_q.val && !out_if.rdy);

    // Classify the beat: packed or dropped, byte count to keep, whether it completes a word.
    always_comb begin
        accept   = in_if.val && in_if.rdy;
        // In IDLE only a sop beat can open a packet; anything else is dropped.
        use_beat = accept && (beat.sop || (state_q == ST_ACCUM));
        if (beat.eop) begin
            vbc_eff = clamp_vbc(beat.vbc);
            bad_vbc = (beat.vbc == '0) || (beat.vbc > IN_VBC);
        end else begin
            // Non-final beats are always full; a short count is reported and ignored.
            vbc_eff = IN_VBC;
            bad_vbc = (beat.vbc != IN_VBC);
        end
        flush      = use_beat && (beat.eop || (beat_idx == BIDX_W'(BEATS - 1)));
        proto_err  = accept && (((state_q == ST_ACCUM) && beat.sop) ||
                                ((state_q == ST_IDLE) && !beat.sop) ||
                                (use_beat && bad_vbc));
        word_first = beat.sop || first_q;
        word_vbc   = VBC_W'(beat_idx) * IN_VBC + vbc_eff;
    end

    c3po_pack_acc u_acc (
        .clk       (clk),
        .reset     (reset),
        .load_i    (use_beat),
        .restart_i (beat.sop),
        .flush_i   (flush),
        .vbc_i     (vbc_eff),
        .data_i    (beat.data),
        .merged_o  (merged),
        .beat_o    (beat_idx)
    );

    // Packet FSM, sop tracking, output word register and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= proto_err;
            case (state_q)
                ST_IDLE:  if (use_beat && !beat.eop) state_q <= ST_ACCUM;
                ST_ACCUM: if (use_beat && beat.eop)  state_q <= ST_IDLE;
            endcase
            if (use_beat) begin
                // After any flush the following word of the packet is no longer the first.
                first_q <= flush ? 1'b0 : word_first;
            end
            if (flush) begin
                // A new word may replace one draining on this same edge.
                out_q <= '{val: 1'b1, sop: word_first, eop: beat.eop,
                           vbc: word_vbc, data: merged};
            end else if (out_q.val && out_if.rdy) begin
                out_q.val <= 1'b0;
            end
        end
    end

    assign out_if.val  = out_q.val;
    assign out_if.sop  = out_q.sop;
    assign out_if.eop  = out_q.eop;
    assign out_if.vbc  = out_q.vbc;
    assign out_if.data = out_q.data;
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_c3po_packer.sv
// Bench for c3po_packer: packet-level byte model feeding an expected-word queue,
// a table of packet lengths, hand sequences for stalls/errors/reset and a random run.
module tb_c3po_packer;
  import c3po_pkg::*;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [7:0]       vbc;
    logic [OUT_W-1:0] data;
  } word_t;

  typedef struct {
    int len;
    int exp_words;
    int exp_last_vbc;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          err;
  packer_state_e dbg_state;

  c3po_packer_if #(.BYTES(IN_BYTES))  nar_if ();
  c3po_packer_if #(.BYTES(OUT_BYTES)) wid_if ();

  c3po_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (nar_if),
    .out_if    (wid_if),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         err_cnt = 0;
  int         rx_words = 0;
  logic [7:0] rx_last_vbc = '0;
  logic       rnd_rdy = 1'b0;
  word_t      exp_q[$];
  logic [7:0] pkt[$];
  word_t      mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (err) err_cnt++;
      if (wid_if.val && wid_if.rdy) begin
        rx_words++;
        rx_last_vbc = wid_if.vbc;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_word: got word vbc %0d sop %b eop %b expected no word",
                   wid_if.vbc, wid_if.sop, wid_if.eop);
        end else begin
          mon_w = exp_q.pop_front();
          if (wid_if.sop === mon_w.sop && wid_if.eop === mon_w.eop &&
              wid_if.vbc === mon_w.vbc && wid_if.data === mon_w.data) begin
            pass_cnt++;
          end else begin
            $display("FAIL word: got sop %b eop %b vbc %0d data_ok %b expected sop %b eop %b vbc %0d",
                     wid_if.sop, wid_if.eop, wid_if.vbc, (wid_if.data === mon_w.data),
                     mon_w.sop, mon_w.eop, mon_w.vbc);
          end
        end
      end
    end
  end

  // Random backpressure on the wide side when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) wid_if.rdy = ($urandom_range(0, 9) < 7);
    end
  end

  // ---------------- reference model ----------------
  // A packet is a byte string; it leaves as consecutive 160-byte slices.
  task automatic model_push(input int len);
    word_t w;
    for (int off = 0; off < len; off += OUT_BYTES) begin
      w = '0;
      w.sop = (off == 0);
      w.eop = (off + OUT_BYTES >= len);
      w.vbc = 8'((len - off > OUT_BYTES) ? OUT_BYTES : (len - off));
      for (int k = 0; k < int'(w.vbc); k++) w.data[8*k +: 8] = pkt[off + k];
      exp_q.push_back(w);
    end
  endtask

  task automatic fill_pkt(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic sop, input logic eop, input logic [7:0] vbc,
                           input logic [IN_W-1:0] data);
    int n = 0;
    nar_if.val  = 1'b1;
    nar_if.sop  = sop;
    nar_if.eop  = eop;
    nar_if.vbc  = vbc;
    nar_if.data = data;
    @(negedge clk);
    while (!nar_if.rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!nar_if.rdy) begin
      chk_cnt++;
      $display("FAIL beat_timeout: got i_rdy 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    nar_if.val = 1'b0;
    nar_if.sop = 1'b0;
    nar_if.eop = 1'b0;
  endtask

  function automatic logic [IN_W-1:0] beat_bytes(input int first, input int cnt);
    logic [IN_W-1:0] d = '0;
    for (int k = 0; k < cnt; k++) d[8*k +: 8] = pkt[first + k];
    return d;
  endfunction

  task automatic send_packet(input int len, input int gap_max);
    int nb;
    int vbc;
    fill_pkt(len);
    model_push(len);
    nb = (len + IN_BYTES - 1) / IN_BYTES;
    for (int b = 0; b < nb; b++) begin
      vbc = (b == nb - 1) ? (len - IN_BYTES * b) : IN_BYTES;
      send_beat(b == 0, b == nb - 1, 8'(vbc), beat_bytes(IN_BYTES * b, vbc));
      if (gap_max > 0) cycles($urandom_range(0, gap_max));
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || wid_if.val) && n < 2000) begin
      cycles(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t       vecs[9];
  word_t      snap;
  int         e0;
  int         len;

  initial begin
    vecs[0] = '{160, 1, 160};
    vecs[1] = '{202, 2, 42};
    vecs[2] = '{234, 2, 74};
    vecs[3] = '{1,   1, 1};
    vecs[4] = '{32,  1, 32};
    vecs[5] = '{33,  1, 33};
    vecs[6] = '{320, 2, 160};
    vecs[7] = '{161, 2, 1};
    vecs[8] = '{480, 3, 160};

    nar_if.val = 1'b0; nar_if.sop = 1'b0; nar_if.eop = 1'b0;
    nar_if.vbc = '0;   nar_if.data = '0;
    wid_if.rdy = 1'b1;

    // Reset state
    cycles(3);
    check("rst_o_val", 32'(wid_if.val), 32'd0);
    check("rst_o_sop_eop", 32'({wid_if.sop, wid_if.eop}), 32'd0);
    check("rst_o_vbc", 32'(wid_if.vbc), 32'd0);
    check("rst_o_data_zero", 32'(wid_if.data == '0), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    cycles(1);
    check("rst_i_rdy", 32'(nar_if.rdy), 32'd1);

    // Five full beats: one word, o_val one cycle after the last beat
    send_packet(160, 0);
    check("t1_latency_o_val", 32'(wid_if.val), 32'd1);
    check("t1_sop_eop", 32'({wid_if.sop, wid_if.eop}), 32'd3);
    check("t1_vbc", 32'(wid_if.vbc), 32'd160);
    drain("t1_drain");

    // Table of packet lengths
    for (int i = 0; i < 9; i++) begin
      rx_words = 0;
      send_packet(vecs[i].len, 1);
      drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_words", i), 32'(rx_words), 32'(vecs[i].exp_words));
      check($sformatf("vec%0d_last_vbc", i), 32'(rx_last_vbc), 32'(vecs[i].exp_last_vbc));
    end

    // Single one-byte packet
    send_packet(1, 0);
    check("t3_vbc", 32'(wid_if.vbc), 32'd1);
    check("t3_byte0", 32'(wid_if.data[7:0]), 32'(pkt[0]));
    check("t3_rest_zero", 32'((wid_if.data >> 8) == '0), 32'd1);
    drain("t3_drain");

    // Wide side stalled for three cycles after a flush
    wid_if.rdy = 1'b0;
    send_packet(160, 0);
    snap = '{wid_if.sop, wid_if.eop, wid_if.vbc, wid_if.data};
    for (int c = 0; c < 3; c++) begin
      check("t4_i_rdy_low", 32'(nar_if.rdy), 32'd0);
      check("t4_o_val_held", 32'(wid_if.val), 32'd1);
      check("t4_word_stable",
            32'(snap == {wid_if.sop, wid_if.eop, wid_if.vbc, wid_if.data}), 32'd1);
      cycles(1);
    end
    wid_if.rdy = 1'b1;
    send_packet(320, 0);
    send_packet(100, 0);
    send_packet(1, 0);
    send_packet(1, 0);
    send_packet(160, 0);
    drain("t4_drain");

    // sop arrives at beat 2 of an open packet
    e0 = err_cnt;
    fill_pkt(64);
    send_beat(1'b1, 1'b0, 8'd32, beat_bytes(0, 32));
    send_beat(1'b0, 1'b0, 8'd32, beat_bytes(32, 32));
    send_packet(100, 0);
    drain("t5_drain");
    check("t5_err_pulses", 32'(err_cnt - e0), 32'd1);

    // Beat without sop while idle is dropped
    e0 = err_cnt;
    fill_pkt(32);
    send_beat(1'b0, 1'b1, 8'd32, beat_bytes(0, 32));
    cycles(3);
    check("drop_err", 32'(err_cnt - e0), 32'd1);
    check("drop_state", 32'(dbg_state), 32'(ST_IDLE));
    check("drop_no_word", 32'(exp_q.size()), 32'd0);

    // Final beat with vbc 0 becomes a one-byte beat
    e0 = err_cnt;
    fill_pkt(1);
    model_push(1);
    send_beat(1'b1, 1'b1, 8'd0, {IN_W{1'b1}} ^ {{(IN_W-8){1'b1}}, ~pkt[0]});
    drain("vbc0_drain");
    check("vbc0_err", 32'(err_cnt - e0), 32'd1);

    // Final beat with vbc 40 becomes a full beat
    e0 = err_cnt;
    fill_pkt(32);
    model_push(32);
    send_beat(1'b1, 1'b1, 8'd40, beat_bytes(0, 32));
    drain("vbc40_drain");
    check("vbc40_err", 32'(err_cnt - e0), 32'd1);

    // Short middle beat is still packed as a full beat
    e0 = err_cnt;
    fill_pkt(64);
    model_push(64);
    send_beat(1'b1, 1'b0, 8'd5, beat_bytes(0, 32));
    send_beat(1'b0, 1'b1, 8'd32, beat_bytes(32, 32));
    drain("short_mid_drain");
    check("short_mid_err", 32'(err_cnt - e0), 32'd1);

    // Reset after beat 3 of a packet
    fill_pkt(128);
    for (int b = 0; b < 4; b++) send_beat(b == 0, 1'b0, 8'd32, beat_bytes(32 * b, 32));
    reset = 1'b1;
    #1;
    check("t6_o_val", 32'(wid_if.val), 32'd0);
    check("t6_o_vbc", 32'(wid_if.vbc), 32'd0);
    check("t6_o_data_zero", 32'(wid_if.data == '0), 32'd1);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    cycles(2);
    reset = 1'b0;
    cycles(1);
    send_packet(100, 0);
    check("t6_vbc_after", 32'(wid_if.vbc), 32'd100);
    drain("t6_drain");

    // Random packets with gaps and random backpressure
    e0 = err_cnt;
    rnd_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) len = OUT_BYTES * $urandom_range(1, 2);
      else len = $urandom_range(1, 420);
      send_packet(len, 2);
    end
    rnd_rdy = 1'b0;
    wid_if.rdy = 1'b1;
    drain("rnd_drain");
    check("rnd_no_err", 32'(err_cnt - e0), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
